// File: rtl/std_skidbuf_ctrl.sv
// Two-entry valid/ready register slice (skid buffer) with registered s_ready and m_valid.
// A 3-state FSM sequences the enables of the un-reset main and skid data registers.
module std_skidbuf_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy,
    output logic [1:0]            state_dbg
);

    // Handshakes (both sides): a beat transfers on a rising clk edge where
    // valid and ready are both high. s_ready and m_valid are flops, so no
    // combinational path exists between m_ready and s_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nx;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_en;
    logic                  skid_en;
    logic                  main_sel_skid;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_fire  = s_valid & s_ready;
    assign out_fire = m_valid & m_ready;

    always_comb begin
        state_nx = state_q;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_nx = BUSY;
                BUSY: begin
                    if (in_fire && !out_fire)      state_nx = FULL;
                    else if (!in_fire && out_fire) state_nx = EMPTY;
                end
                FULL:    if (out_fire) state_nx = BUSY;
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Flush suppresses every load so a flushed beat never reaches the registers.
    always_comb begin
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = (state_q == FULL);
        if (!flush) begin
            main_en = ((state_q == EMPTY) && in_fire)
                    | ((state_q == BUSY) && in_fire && out_fire)
                    | ((state_q == FULL) && out_fire);
            skid_en = (state_q == BUSY) && in_fire && !out_fire;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q <= state_nx;
            case (state_nx)
                BUSY: begin
                    s_ready   <= 1'b1;
                    m_valid   <= 1'b1;
                    occupancy <= 2'd1;
                end
                FULL: begin
                    s_ready   <= 1'b0;
                    m_valid   <= 1'b1;
                    occupancy <= 2'd2;
                end
                default: begin
                    s_ready   <= 1'b1;
                    m_valid   <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

    // Data path carries no reset; contents are meaningful only while m_valid is high.
    always_ff @(posedge clk) begin
        if (main_en) main_q <= main_sel_skid ? skid_q : s_data;
        if (skid_en) skid_q <= s_data;
    end

    assign m_data    = main_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_std_skidbuf_ctrl.sv
// Bench for std_skidbuf_ctrl: a queue-of-beats reference model checked every cycle,
// directed stream/backpressure/flush/reset scenarios and a randomized 1000-beat run.
module tb_std_skidbuf_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [1:0]   occupancy;
    logic [1:0]   state_dbg;

    int n_checks;
    int n_fail;
    int n_acc;
    int n_del;
    bit last_in_fire;

    logic [W-1:0] exp_q[$];

    std_skidbuf_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".s_ready"}, W'(s_ready), W'(exp_q.size() < 2));
        chk({tag, ".m_valid"}, W'(m_valid), W'(exp_q.size() > 0));
        chk({tag, ".occupancy"}, W'(occupancy), W'(exp_q.size()));
        if (exp_q.size() > 0) chk({tag, ".m_data"}, m_data, exp_q[0]);
    endtask

    task automatic drive(input bit sv, input logic [W-1:0] sd, input bit mr, input bit fl);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
    endtask

    // One clock: update the beat queue from the driven inputs, then check at negedge.
    task automatic tick(input string tag);
        bit in_f;
        bit out_f;
        @(posedge clk);
        in_f  = s_valid && (exp_q.size() < 2);
        out_f = m_ready && (exp_q.size() > 0);
        last_in_fire = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_f) begin
                void'(exp_q.pop_front());
                n_del++;
            end
            if (in_f) begin
                exp_q.push_back(s_data);
                n_acc++;
                last_in_fire = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        drive(0, '0, 1, 0);
        while (exp_q.size() > 0 && k < budget) begin
            tick(tag);
            k++;
        end
        if (exp_q.size() > 0) chk({tag, ".drain_timeout"}, W'(exp_q.size()), W'(0));
    endtask

    initial begin
        logic [W-1:0] held;
        bit           stall;
        int           cyc;
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        n_del    = 0;
        reset    = 1'b1;
        drive(0, '0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;
        tick("idle");

        // Stream 1..4 with m_ready high: occupancy stays at 1.
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 1, 0);
            tick("stream");
            chk("stream.occ1", W'(occupancy), W'(1));
            chk("stream.data", m_data, W'(i));
        end
        drain("stream_drain", 10);

        // Backpressure: A then B with m_ready low fills both entries.
        drive(1, 32'hA, 0, 0);
        tick("bp_a");
        drive(1, 32'hB, 0, 0);
        tick("bp_b");
        chk("bp.full_occ", W'(occupancy), W'(2));
        chk("bp.full_sready", W'(s_ready), W'(0));
        chk("bp.head", m_data, 32'hA);
        // Stall while full, offering C which must not be accepted.
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'hC, 0, 0);
            tick("stall");
        end
        chk("stall.head", m_data, 32'hA);
        drive(1, 32'hC, 1, 0);
        tick("drain_a");
        chk("drain.second", m_data, 32'hB);
        drive(1, 32'hC, 1, 0);
        tick("drain_b_take_c");
        drive(0, '0, 0, 0);
        tick("c_wait");
        chk("drain.third", m_data, 32'hC);
        drain("bp_drain", 10);
        chk("bp.empty", W'(m_valid), W'(0));

        // Flush while FULL with a beat offered: D must be dropped.
        drive(1, 32'h11, 0, 0);
        tick("fl_fill1");
        drive(1, 32'h12, 0, 0);
        tick("fl_fill2");
        drive(1, 32'hD, 0, 1);
        tick("flush_full");
        chk("flush_full.mvalid", W'(m_valid), W'(0));
        chk("flush_full.occ", W'(occupancy), W'(0));
        drive(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) tick("post_flush");

        // Flush while BUSY with m_ready high.
        drive(1, 32'h21, 1, 0);
        tick("fl_busy_fill");
        drive(0, '0, 1, 1);
        tick("flush_busy");
        chk("flush_busy.occ", W'(occupancy), W'(0));

        // Asynchronous reset with the slice FULL.
        drive(1, 32'h31, 0, 0);
        tick("rst_fill1");
        drive(1, 32'h32, 0, 0);
        tick("rst_fill2");
        drive(0, '0, 0, 0);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst.s_ready", W'(s_ready), W'(1));
        chk("async_rst.m_valid", W'(m_valid), W'(0));
        chk("async_rst.occ", W'(occupancy), W'(0));
        @(negedge clk);
        reset = 1'b0;
        tick("after_rst");

        // Randomized: 1000 sequential payloads, random valid/ready, upstream holds until accepted.
        n_acc = 0;
        n_del = 0;
        cyc   = 0;
        drive(0, '0, 0, 0);
        last_in_fire = 1'b0;
        while (n_del < 1000 && cyc < 20000) begin
            if (!s_valid || last_in_fire) begin
                s_valid = (n_acc < 1000) && ($urandom_range(0, 99) < 70);
                s_data  = 32'h1000_0000 + W'(n_acc);
            end
            m_ready = ($urandom_range(0, 99) < 60);
            stall   = (exp_q.size() > 0) && !m_ready;
            held    = (exp_q.size() > 0) ? exp_q[0] : '0;
            tick("rand");
            if (stall) chk("rand.stable", m_data, held);
            cyc++;
        end
        chk("rand.delivered", W'(n_del), W'(1000));
        chk("rand.accepted", W'(n_acc), W'(1000));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
